// File: rtl/reg_file_arbiter_if.sv
// Request/grant bus between the two requesters, the arbiter and the register file.
// The arbiter uses the slave modport; requesters and register file sit on the master side.
interface reg_file_arbiter_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned AW     = 3
);
    // requester side
    logic              req_a;
    logic              req_b;
    logic              we_a;
    logic              we_b;
    logic [AW-1:0]     addr_a;
    logic [AW-1:0]     addr_b;
    logic [DATA_W-1:0] wdata_a;
    logic [DATA_W-1:0] wdata_b;
    logic              gnt_a;
    logic              gnt_b;
    logic              rvalid_a;
    logic              rvalid_b;
    logic [DATA_W-1:0] rdata;
    // register-file side
    logic              rf_ld;
    logic [AW-1:0]     rf_dr;
    logic [AW-1:0]     rf_sr1;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_sr1_out;
    // status
    logic              busy;

    modport master (
        output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, rf_sr1_out,
        input  gnt_a, gnt_b, rvalid_a, rvalid_b, rdata, rf_ld, rf_dr, rf_sr1, rf_wdata, busy
    );

    modport slave (
        input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, rf_sr1_out,
        output gnt_a, gnt_b, rvalid_a, rvalid_b, rdata, rf_ld, rf_dr, rf_sr1, rf_wdata, busy
    );
endinterface

// File: rtl/reg_file_arbiter.sv
// Two-requester round-robin arbiter in front of a single-write/single-read register file.
// Requester A is the datapath, B is the debug port. Every output is registered.
// Optional feature: define RF_CLEAR_ON_RESET_EN to zero every register after reset
// (one register per cycle, busy high, requests ignored meanwhile).
module reg_file_arbiter #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned AW     = 3
) (
    input logic               Clk,
    input logic               Reset,
    reg_file_arbiter_if.slave bus
);

    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_GRANT = 2'd2;

`ifdef RF_CLEAR_ON_RESET_EN
    localparam logic [1:0]    ST_RESET = ST_CLEAR;
    localparam logic [AW-1:0] LAST_IDX = {AW{1'b1}};
`else
    localparam logic [1:0]    ST_RESET = ST_IDLE;
`endif

    logic [1:0]        r_state;
    logic              r_ptr;          // 0 = A has priority, 1 = B has priority
    logic              r_gnt_a;
    logic              r_gnt_b;
    logic              r_rvalid_a;
    logic              r_rvalid_b;
    logic              r_rd_pend_a;    // read granted this cycle, data captured at its end
    logic              r_rd_pend_b;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rf_ld;
    logic [AW-1:0]     r_rf_dr;
    logic [AW-1:0]     r_rf_sr1;
    logic [DATA_W-1:0] r_rf_wdata;
`ifdef RF_CLEAR_ON_RESET_EN
    logic [AW-1:0]     r_clr_cnt;
    logic              r_busy;
`endif

    logic              w_any_req;
    logic              w_pick_b;
    logic              w_we;
    logic [AW-1:0]     w_addr;
    logic [DATA_W-1:0] w_wdata;

    // Choose the winner among the current requests and mux its command fields.
    always_comb begin
        w_any_req = bus.req_a | bus.req_b;
        if (bus.req_a && bus.req_b) begin
            w_pick_b = r_ptr;
        end else begin
            w_pick_b = bus.req_b;
        end
        w_we    = w_pick_b ? bus.we_b    : bus.we_a;
        w_addr  = w_pick_b ? bus.addr_b  : bus.addr_a;
        w_wdata = w_pick_b ? bus.wdata_b : bus.wdata_a;
    end

    // State machine and all registered outputs; strobes default low every cycle.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state     <= ST_RESET;
            r_ptr       <= 1'b0;
            r_gnt_a     <= 1'b0;
            r_gnt_b     <= 1'b0;
            r_rvalid_a  <= 1'b0;
            r_rvalid_b  <= 1'b0;
            r_rd_pend_a <= 1'b0;
            r_rd_pend_b <= 1'b0;
            r_rdata     <= '0;
            r_rf_ld     <= 1'b0;
            r_rf_dr     <= '0;
            r_rf_sr1    <= '0;
            r_rf_wdata  <= '0;
`ifdef RF_CLEAR_ON_RESET_EN
            r_clr_cnt   <= '0;
            r_busy      <= 1'b1;
`endif
        end else begin
            r_gnt_a    <= 1'b0;
            r_gnt_b    <= 1'b0;
            r_rvalid_a <= 1'b0;
            r_rvalid_b <= 1'b0;
            r_rf_ld    <= 1'b0;
            case (r_state)
`ifdef RF_CLEAR_ON_RESET_EN
                ST_CLEAR: begin
                    // The write for index k is presented in the cycle after k is counted,
                    // so the last write lands in the first IDLE cycle.
                    r_rf_ld    <= 1'b1;
                    r_rf_dr    <= r_clr_cnt;
                    r_rf_wdata <= '0;
                    r_clr_cnt  <= r_clr_cnt + 1'b1;
                    if (r_clr_cnt == LAST_IDX) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
`endif
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_state     <= ST_GRANT;
                        r_gnt_a     <= ~w_pick_b;
                        r_gnt_b     <= w_pick_b;
                        r_rf_ld     <= w_we;
                        r_rf_dr     <= w_addr;
                        r_rf_sr1    <= w_addr;
                        r_rf_wdata  <= w_wdata;
                        r_rd_pend_a <= ~w_pick_b & ~w_we;
                        r_rd_pend_b <= w_pick_b & ~w_we;
                        // Pointer always moves to the loser, even with a single requester.
                        r_ptr       <= ~w_pick_b;
                    end
                end
                ST_GRANT: begin
                    // Requests are not sampled here, which spaces grants two cycles apart.
                    r_state     <= ST_IDLE;
                    if (r_rd_pend_a || r_rd_pend_b) begin
                        r_rdata <= bus.rf_sr1_out;
                    end
                    r_rvalid_a  <= r_rd_pend_a;
                    r_rvalid_b  <= r_rd_pend_b;
                    r_rd_pend_a <= 1'b0;
                    r_rd_pend_b <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt_a    = r_gnt_a;
    assign bus.gnt_b    = r_gnt_b;
    assign bus.rvalid_a = r_rvalid_a;
    assign bus.rvalid_b = r_rvalid_b;
    assign bus.rdata    = r_rdata;
    assign bus.rf_ld    = r_rf_ld;
    assign bus.rf_dr    = r_rf_dr;
    assign bus.rf_sr1   = r_rf_sr1;
    assign bus.rf_wdata = r_rf_wdata;
`ifdef RF_CLEAR_ON_RESET_EN
    assign bus.busy     = r_busy;
`else
    assign bus.busy     = 1'b0;
`endif

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Bench for reg_file_arbiter: scoreboard queues of expected grants and read data,
// a behavioural register file on the rf_* side, one task per scenario.
// Optional RF_CLEAR_ON_RESET_EN build adds the clear-sequence scenario.
module tb_reg_file_arbiter;

    localparam int unsigned DW = 16;
    localparam int unsigned AWB = 3;

    typedef struct packed {
        logic          who;    // 0 = A, 1 = B
        logic          we;
        logic [AWB-1:0] addr;
        logic [DW-1:0] wdata;
    } gnt_exp_t;

    typedef struct packed {
        logic          who;
        logic [DW-1:0] data;
    } rd_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    gnt_exp_t      gq[$];
    rd_exp_t       rq[$];
    logic [DW-1:0] exp_mem [8];
    logic [DW-1:0] exp_rdata;
    logic [DW-1:0] rf_mem [8] = '{default: '0};

    reg_file_arbiter_if #(.DATA_W(DW), .AW(AWB)) bus ();

    reg_file_arbiter #(.DATA_W(DW), .AW(AWB)) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural register file driven by the arbiter.
    always @(posedge clk) begin
        if (bus.rf_ld) rf_mem[bus.rf_dr] <= bus.rf_wdata;
    end
    assign bus.rf_sr1_out = rf_mem[bus.rf_sr1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        bus.req_a = 1'b0; bus.we_a = 1'b0; bus.addr_a = '0; bus.wdata_a = '0;
        bus.req_b = 1'b0; bus.we_b = 1'b0; bus.addr_b = '0; bus.wdata_b = '0;
    endtask

    task automatic drive_req(input logic who, input logic we, input logic [AWB-1:0] addr,
                             input logic [DW-1:0] wdata);
        if (who) begin
            bus.req_b = 1'b1; bus.we_b = we; bus.addr_b = addr; bus.wdata_b = wdata;
        end else begin
            bus.req_a = 1'b1; bus.we_a = we; bus.addr_a = addr; bus.wdata_a = wdata;
        end
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        exp_rdata = '0;
`ifdef RF_CLEAR_ON_RESET_EN
        for (int i = 0; i < 8; i++) exp_mem[i] = '0;
        repeat (8) tick();
`endif
    endtask

    task automatic test_reset();
        logic exp_busy;
`ifdef RF_CLEAR_ON_RESET_EN
        exp_busy = 1'b1;
`else
        exp_busy = 1'b0;
`endif
        clear_reqs();
        rst_n = 1'b0;
        tick();
        tick();
        n_tests++;
        if ({bus.gnt_a, bus.gnt_b, bus.rvalid_a, bus.rvalid_b, bus.rf_ld} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_strobes got %b want 00000",
                     {bus.gnt_a, bus.gnt_b, bus.rvalid_a, bus.rvalid_b, bus.rf_ld});
        end
        n_tests++;
        if (bus.rdata !== '0 || bus.rf_wdata !== '0) begin
            n_fail++;
            $display("FAIL reset_data rdata=%h rf_wdata=%h want 0", bus.rdata, bus.rf_wdata);
        end
        n_tests++;
        if (bus.rf_dr !== '0 || bus.rf_sr1 !== '0) begin
            n_fail++;
            $display("FAIL reset_index rf_dr=%0d rf_sr1=%0d want 0", bus.rf_dr, bus.rf_sr1);
        end
        n_tests++;
        if (bus.busy !== exp_busy) begin
            n_fail++;
            $display("FAIL reset_busy got %b want %b", bus.busy, exp_busy);
        end
        release_reset();
    endtask

    // Single transactions, one at a time, every two cycles.
    task automatic test_single_txns();
        gnt_exp_t tbl [8];
        gnt_exp_t g;
        rd_exp_t  r;
        logic [AWB-1:0] ra;
        ra = 3'($urandom_range(7, 0));
        tbl[0] = '{1'b0, 1'b1, 3'd5, 16'hECEB};
        tbl[1] = '{1'b1, 1'b0, 3'd5, 16'h0000};
        tbl[2] = '{1'b0, 1'b1, 3'd1, 16'hF0F0};
        tbl[3] = '{1'b1, 1'b0, 3'd1, 16'h5555};
        tbl[4] = '{1'b1, 1'b1, 3'd7, 16'h1357};
        tbl[5] = '{1'b0, 1'b0, 3'd7, 16'hAAAA};
        tbl[6] = '{1'b0, 1'b1, ra, 16'($urandom)};
        tbl[7] = '{1'b1, 1'b0, ra, 16'h0001};
        for (int i = 0; i < 8; i++) begin
            drive_req(tbl[i].who, tbl[i].we, tbl[i].addr, tbl[i].wdata);
            gq.push_back(tbl[i]);
            if (!tbl[i].we) rq.push_back('{tbl[i].who, exp_mem[tbl[i].addr]});
            tick();
            clear_reqs();
            g = gq.pop_front();
            n_tests++;
            if ({bus.gnt_b, bus.gnt_a} !== (g.who ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL single_gnt[%0d] got b/a=%b%b want who=%0d",
                         i, bus.gnt_b, bus.gnt_a, g.who);
            end
            n_tests++;
            if (bus.rf_ld !== g.we || bus.rf_dr !== g.addr || bus.rf_sr1 !== g.addr ||
                bus.rf_wdata !== g.wdata) begin
                n_fail++;
                $display("FAIL single_cmd[%0d] ld=%b dr=%0d sr1=%0d wd=%h want %b %0d %0d %h",
                         i, bus.rf_ld, bus.rf_dr, bus.rf_sr1, bus.rf_wdata,
                         g.we, g.addr, g.addr, g.wdata);
            end
            if (g.we) exp_mem[g.addr] = g.wdata;
            tick();
            if (!g.we) begin
                r = rq.pop_front();
                exp_rdata = r.data;
                n_tests++;
                if ({bus.gnt_b, bus.gnt_a, bus.rvalid_b, bus.rvalid_a} !==
                    (r.who ? 4'b0010 : 4'b0001) || bus.rdata !== r.data) begin
                    n_fail++;
                    $display("FAIL single_read[%0d] gnt=%b%b rv=%b%b rdata=%h want who=%0d %h",
                             i, bus.gnt_b, bus.gnt_a, bus.rvalid_b, bus.rvalid_a, bus.rdata,
                             r.who, r.data);
                end
            end else begin
                n_tests++;
                if ({bus.gnt_b, bus.gnt_a, bus.rvalid_b, bus.rvalid_a, bus.rf_ld} !== 5'b0 ||
                    bus.rdata !== exp_rdata) begin
                    n_fail++;
                    $display("FAIL single_wr_after[%0d] strobes=%b rdata=%h want 0 %h", i,
                             {bus.gnt_b, bus.gnt_a, bus.rvalid_b, bus.rvalid_a, bus.rf_ld},
                             bus.rdata, exp_rdata);
                end
            end
        end
    endtask

    // Both requesting continuously from reset release: A,B,A,B every 2 cycles.
    task automatic test_contention();
        rd_exp_t r;
        logic    exp_b;
        clear_reqs();
        rst_n = 1'b0;
        tick();
        drive_req(1'b0, 1'b0, 3'd1, 16'h0);
        drive_req(1'b1, 1'b0, 3'd5, 16'h0);
        release_reset();
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k % 2 == 0) begin
                exp_b = ((k / 2) % 2) == 1;
                rq.push_back('{exp_b, exp_mem[exp_b ? 3'd5 : 3'd1]});
                n_tests++;
                if ({bus.gnt_b, bus.gnt_a} !== (exp_b ? 2'b10 : 2'b01)) begin
                    n_fail++;
                    $display("FAIL contention_gnt[%0d] got b/a=%b%b want who=%0d",
                             k, bus.gnt_b, bus.gnt_a, exp_b);
                end
            end else begin
                r = rq.pop_front();
                n_tests++;
                if ({bus.gnt_b, bus.gnt_a, bus.rvalid_b, bus.rvalid_a} !==
                    (r.who ? 4'b0010 : 4'b0001) || bus.rdata !== r.data) begin
                    n_fail++;
                    $display("FAIL contention_rv[%0d] gnt=%b%b rv=%b%b rdata=%h want %0d %h",
                             k, bus.gnt_b, bus.gnt_a, bus.rvalid_b, bus.rvalid_a, bus.rdata,
                             r.who, r.data);
                end
                exp_rdata = r.data;
            end
        end
        clear_reqs();
        tick();
        tick();
    endtask

    // Pointer movement with single and dual requesters.
    task automatic test_pointer();
        logic [1:0] pat [7];
        logic [6:0] exp_who;
        rd_exp_t    r;
        pat[0] = 2'b01; pat[1] = 2'b11; pat[2] = 2'b11; pat[3] = 2'b10;
        pat[4] = 2'b11; pat[5] = 2'b01; pat[6] = 2'b11;
        exp_who = 7'b1001010;  // bit i = winner of round i (1 = B)
        clear_reqs();
        rst_n = 1'b0;
        tick();
        release_reset();
        for (int i = 0; i < 7; i++) begin
            if (pat[i][0]) drive_req(1'b0, 1'b0, 3'd2, 16'h0);
            if (pat[i][1]) drive_req(1'b1, 1'b0, 3'd6, 16'h0);
            rq.push_back('{exp_who[i], exp_mem[exp_who[i] ? 3'd6 : 3'd2]});
            tick();
            clear_reqs();
            n_tests++;
            if ({bus.gnt_b, bus.gnt_a} !== (exp_who[i] ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL pointer_gnt[%0d] got b/a=%b%b want who=%0d",
                         i, bus.gnt_b, bus.gnt_a, exp_who[i]);
            end
            tick();
            r = rq.pop_front();
            exp_rdata = r.data;
            n_tests++;
            if ({bus.rvalid_b, bus.rvalid_a} !== (r.who ? 2'b10 : 2'b01) ||
                bus.rdata !== r.data) begin
                n_fail++;
                $display("FAIL pointer_rv[%0d] rv=%b%b rdata=%h want who=%0d %h",
                         i, bus.rvalid_b, bus.rvalid_a, bus.rdata, r.who, r.data);
            end
        end
    endtask

    // Reset asserted during a read grant drops the read and restores pointer to A.
    task automatic test_reset_mid_grant();
        drive_req(1'b0, 1'b0, 3'd3, 16'h0);  // single A grant moves pointer to B
        tick();
        clear_reqs();
        tick();
        drive_req(1'b1, 1'b0, 3'd5, 16'h0);
        tick();
        n_tests++;
        if (bus.gnt_b !== 1'b1) begin
            n_fail++;
            $display("FAIL midgrant_gnt got gnt_b=%b want 1", bus.gnt_b);
        end
        rst_n = 1'b0;
        clear_reqs();
        tick();
        n_tests++;
        if ({bus.gnt_a, bus.gnt_b, bus.rvalid_a, bus.rvalid_b, bus.rf_ld} !== 5'b0 ||
            bus.rdata !== '0 || bus.rf_dr !== '0 || bus.rf_sr1 !== '0 ||
            bus.rf_wdata !== '0) begin
            n_fail++;
            $display("FAIL midgrant_outputs strobes=%b rdata=%h dr=%0d sr1=%0d wd=%h want 0",
                     {bus.gnt_a, bus.gnt_b, bus.rvalid_a, bus.rvalid_b, bus.rf_ld},
                     bus.rdata, bus.rf_dr, bus.rf_sr1, bus.rf_wdata);
        end
        release_reset();
        n_tests++;
        if ({bus.rvalid_a, bus.rvalid_b} !== 2'b00) begin
            n_fail++;
            $display("FAIL midgrant_no_rvalid got rv=%b%b want 00", bus.rvalid_a, bus.rvalid_b);
        end
        drive_req(1'b0, 1'b0, 3'd4, 16'h0);
        drive_req(1'b1, 1'b0, 3'd5, 16'h0);
        tick();
        clear_reqs();
        n_tests++;
        if ({bus.gnt_b, bus.gnt_a} !== 2'b01) begin
            n_fail++;
            $display("FAIL midgrant_ptr got b/a=%b%b want 01", bus.gnt_b, bus.gnt_a);
        end
        tick();
        n_tests++;
        if (bus.rvalid_a !== 1'b1 || bus.rdata !== exp_mem[4]) begin
            n_fail++;
            $display("FAIL midgrant_read rv_a=%b rdata=%h want 1 %h",
                     bus.rvalid_a, bus.rdata, exp_mem[4]);
        end
        exp_rdata = exp_mem[4];
    endtask

`ifdef RF_CLEAR_ON_RESET_EN
    // Preload R3, reset, watch the clear walk, then read R3 back as zero.
    task automatic test_clear();
        drive_req(1'b0, 1'b1, 3'd3, 16'h1234);
        tick();
        clear_reqs();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive_req(1'b0, 1'b0, 3'd3, 16'h0);
        for (int j = 0; j < 8; j++) begin
            n_tests++;
            if (bus.busy !== 1'b1 || bus.gnt_a !== 1'b0 || bus.rf_ld !== (j != 0) ||
                (j != 0 && (bus.rf_dr !== 3'(j - 1) || bus.rf_wdata !== '0))) begin
                n_fail++;
                $display("FAIL clear_walk[%0d] busy=%b gnt_a=%b ld=%b dr=%0d wd=%h",
                         j, bus.busy, bus.gnt_a, bus.rf_ld, bus.rf_dr, bus.rf_wdata);
            end
            tick();
        end
        n_tests++;
        if (bus.busy !== 1'b0 || bus.rf_ld !== 1'b1 || bus.rf_dr !== 3'd7) begin
            n_fail++;
            $display("FAIL clear_end busy=%b ld=%b dr=%0d want 0 1 7",
                     bus.busy, bus.rf_ld, bus.rf_dr);
        end
        for (int i = 0; i < 8; i++) exp_mem[i] = '0;
        tick();
        clear_reqs();
        n_tests++;
        if (bus.gnt_a !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_gnt got gnt_a=%b want 1", bus.gnt_a);
        end
        tick();
        n_tests++;
        if (bus.rvalid_a !== 1'b1 || bus.rdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL clear_read rv_a=%b rdata=%h want 1 0000", bus.rvalid_a, bus.rdata);
        end
        exp_rdata = '0;
    endtask
`endif

    initial begin
        for (int i = 0; i < 8; i++) exp_mem[i] = '0;
        exp_rdata = '0;
        clear_reqs();
        test_reset();
        test_single_txns();
        test_contention();
        test_pointer();
        test_reset_mid_grant();
`ifdef RF_CLEAR_ON_RESET_EN
        test_clear();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_arbiter.md
REG_FILE_ARBITER -- requirements
Module: reg_file_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register word width.
REQ-002 SHALL have parameter AW, default 3, register index width (2**AW registers).
REQ-003 SHALL have port Clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1  reset, synchronous, active-low (0 = reset).
REQ-005 SHALL have ports req_a / req_b  input  1  requester A (datapath) / B (debug) access request.
REQ-006 SHALL have ports we_a / we_b  input  1  1 = write, 0 = read.
REQ-007 SHALL have ports addr_a / addr_b  input  AW  target register index.
REQ-008 SHALL have ports wdata_a / wdata_b  input  DATA_W  write data.
REQ-009 SHALL have ports gnt_a / gnt_b  output  1  one-cycle grant pulse.
REQ-010 SHALL have ports rvalid_a / rvalid_b  output  1  one-cycle read-data-valid pulse.
REQ-011 SHALL have port rdata  output  DATA_W  read data, qualified by rvalid_a/rvalid_b.
REQ-012 SHALL have ports rf_ld (1), rf_dr (AW), rf_sr1 (AW), rf_wdata (DATA_W)  output  register-file write enable, write index, read index, write data.
REQ-013 SHALL have port rf_sr1_out  input  DATA_W  combinational register-file read data for rf_sr1.
REQ-014 SHALL have port busy  output  1  high while the clear sequence runs.

Function
REQ-015 SHALL implement FSM states CLEAR, IDLE, GRANT; all outputs SHALL be registered.
REQ-016 In IDLE, a sampled request SHALL enter GRANT next cycle; with no request, remain in IDLE.
REQ-017 In GRANT: gnt of the winner =1 for exactly one cycle; rf_dr/rf_sr1 = winner addr; rf_wdata = winner wdata; rf_ld = winner we.
REQ-018 Write latency: req sampled in cycle N -> rf_ld=1 in cycle N+1 -> register updated at end of N+1.
REQ-019 Read latency: req sampled in cycle N -> rf_sr1 valid in N+1 -> rdata = rf_sr1_out captured at end of N+1, rvalid_x=1 in N+2.
REQ-020 rdata SHALL hold its value until the next read completes; rf_ld SHALL be 0 outside GRANT/CLEAR.
REQ-021 Simultaneous req_a and req_b: round-robin; 1-bit priority pointer, reset to A, points to the loser after every grant.
REQ-022 A requester holds req and addr/we/wdata stable until its gnt; the GRANT cycle SHALL NOT sample requests, so back-to-back grants are spaced 2 cycles.
REQ-023 A req still high in the cycle after gnt SHALL be treated as a new request.
REQ-024 Single requester: granted regardless of pointer; pointer still moves to the other requester.
REQ-025 Read in cycle after a write to the same index SHALL return the new value (no bypass needed; write completes first).

Reset
REQ-026 Reset=0 at an edge SHALL force: gnt_*, rvalid_*, rf_ld = 0; rdata, rf_dr, rf_sr1, rf_wdata = 0; pointer = A; clear counter = 0.
REQ-027 Reset mid-GRANT SHALL drop that transaction; no rvalid follows; state after release per REQ-029/030.

Configuration
REQ-028 Macro RF_CLEAR_ON_RESET_EN SHALL select the post-reset clear sequence.
REQ-029 Defined: reset state = CLEAR, busy=1; one register per cycle, rf_ld=1, rf_dr=0..2**AW-1, rf_wdata=0 (8 cycles for AW=3); requests ignored; then IDLE, busy=0.
REQ-030 Undefined: reset state = IDLE; CLEAR unreachable; busy tied 0.

Verification
REQ-031 Write A: req_a=1, we_a=1, addr_a=5, wdata_a=xECEB -> next cycle gnt_a=1, rf_ld=1, rf_dr=5, rf_wdata=xECEB.
REQ-032 Read-back: then req_b=1, we_b=0, addr_b=5 -> gnt_b, rf_sr1=5, two cycles after req sampled rvalid_b=1, rdata=xECEB.
REQ-033 Contention: req_a and req_b high continuously from reset release -> grants A,B,A,B every 2 cycles, never both in one cycle.
REQ-034 Same-index RAW: write R1=xF0F0 (A) then read R1 (B) next sample -> rdata=xF0F0.
REQ-035 With RF_CLEAR_ON_RESET_EN: preload R3=x1234, pulse Reset=0 -> busy=1 for 8 cycles, req_a ignored, read R3 afterwards -> x0000.
REQ-036 Reset=0 during read GRANT -> no rvalid, all outputs 0 next cycle, pointer = A.
